// File: rtl/intdst_pkg.sv
// Shared interrupt package: destination-endpoint state encoding and a
// constant-foldable ceiling-log2 helper.
package intdst_pkg;

    typedef enum logic [1:0] {
        INTDST_IDLE  = 2'd0,
        INTDST_PEND  = 2'd1,
        INTDST_SVC   = 2'd2,
        INTDST_DRAIN = 2'd3
    } intdst_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/intdst_satcnt.sv
// Generic saturating up-counter with synchronous clear; holds at MAX.
module intdst_satcnt #(
    parameter int             W   = 4,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/intdst.sv
// Per-core interrupt destination endpoint: takes the controller's request,
// drives the core irq, and follows intack/eoi through to completion.
//
// state | meaning
// IDLE  | no interrupt held; advertises ready/best to the dispatcher
// PEND  | request latched; irq to core gated by core_inten_i
// SVC   | core vectored into handler; waiting for return-from-interrupt
// DRAIN | handler returned but controller request still high
module intdst
    import intdst_pkg::*;
#(
    parameter int BESTDLY   = 8,
    parameter int ARCHBITSZ = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 intrqst_i,
    output logic                 intrdy_o,
    output logic                 intbest_o,
    input  logic                 core_inten_i,
    input  logic                 core_halted_i,
    output logic                 core_irq_o,
    input  logic                 core_intack_i,
    input  logic                 core_eoi_i,
    output logic [ARCHBITSZ-1:0] intcnt_o
);

    localparam int             BW       = clog2(BESTDLY + 1);
    localparam logic [BW-1:0]  BEST_MAX = BW'(BESTDLY);

    intdst_state_e          r_state;
    intdst_state_e          w_state_nxt;
    logic                   w_irq;
    logic                   w_done;
    logic                   w_best_clr;
    logic [BW-1:0]          w_best_cnt;
    logic                   r_intrdy;
    logic                   r_intbest;
    logic [ARCHBITSZ-1:0]   r_intcnt;

    always_comb begin
        w_state_nxt = r_state;
        w_irq       = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            INTDST_IDLE: begin
                if (intrqst_i) w_state_nxt = INTDST_PEND;
            end
            INTDST_PEND: begin
                // Request stays latched while masked; only a visible irq can be acked.
                w_irq = core_inten_i;
                if (core_inten_i && core_intack_i) w_state_nxt = INTDST_SVC;
            end
            INTDST_SVC: begin
                if (core_eoi_i) begin
                    if (intrqst_i) begin
                        w_state_nxt = INTDST_DRAIN;
                    end else begin
                        w_state_nxt = INTDST_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            INTDST_DRAIN: begin
                if (!intrqst_i) begin
                    w_state_nxt = INTDST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = INTDST_IDLE;
        endcase
    end

    assign w_best_clr = !core_halted_i || (r_state != INTDST_IDLE);

    intdst_satcnt #(
        .W   (BW),
        .MAX (BEST_MAX)
    ) u_best_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_clr   (w_best_clr),
        .o_cnt   (w_best_cnt)
    );

    // Best is qualified with live halted and next state so it drops one edge
    // after either halted falls or a request is accepted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= INTDST_IDLE;
            r_intrdy  <= 1'b0;
            r_intbest <= 1'b0;
            r_intcnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_intrdy  <= (w_state_nxt == INTDST_IDLE) && core_inten_i && !intrqst_i;
            r_intbest <= (w_best_cnt == BEST_MAX) && core_halted_i &&
                         (w_state_nxt == INTDST_IDLE);
            if (w_done) r_intcnt <= r_intcnt + 1'b1;
        end
    end

    assign intrdy_o   = r_intrdy;
    assign intbest_o  = r_intbest;
    assign core_irq_o = w_irq;
    assign intcnt_o   = r_intcnt;

endmodule

// File: tb/tb_intdst.sv
// Directed self-checking bench for intdst (BESTDLY=8, ARCHBITSZ=4).
module tb_intdst;
    import intdst_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       intrqst_i;
    logic       intrdy_o;
    logic       intbest_o;
    logic       core_inten_i;
    logic       core_halted_i;
    logic       core_irq_o;
    logic       core_intack_i;
    logic       core_eoi_i;
    logic [3:0] intcnt_o;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_cnt  = 4'd0;

    intdst #(.BESTDLY(8), .ARCHBITSZ(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .intrqst_i     (intrqst_i),
        .intrdy_o      (intrdy_o),
        .intbest_o     (intbest_o),
        .core_inten_i  (core_inten_i),
        .core_halted_i (core_halted_i),
        .core_irq_o    (core_irq_o),
        .core_intack_i (core_intack_i),
        .core_eoi_i    (core_eoi_i),
        .intcnt_o      (intcnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; intrqst_i = 1'b0; core_inten_i = 1'b0; core_halted_i = 1'b0;
        core_intack_i = 1'b0; core_eoi_i = 1'b0;
        step(); step();
        checks++; if (core_irq_o !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", core_irq_o); end
        checks++; if (intrdy_o !== 1'b0) begin failures++; $display("FAIL rst_rdy got=%b exp=0", intrdy_o); end
        checks++; if (intbest_o !== 1'b0) begin failures++; $display("FAIL rst_best got=%b exp=0", intbest_o); end
        checks++; if (intcnt_o !== 4'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", intcnt_o); end
        rst_ni = 1'b1; core_inten_i = 1'b1;
        step();
        checks++; if (intrdy_o !== 1'b1) begin failures++; $display("FAIL rst_rdy_rise got=%b exp=1", intrdy_o); end
    endtask

    task automatic test_enabled_path();
        intrqst_i = 1'b1;
        step();
        checks++; if (core_irq_o !== 1'b1) begin failures++; $display("FAIL en_irq got=%b exp=1", core_irq_o); end
        checks++; if (intrdy_o !== 1'b0) begin failures++; $display("FAIL en_rdy_fall got=%b exp=0", intrdy_o); end
        step(); step(); step();
        checks++; if (core_irq_o !== 1'b1) begin failures++; $display("FAIL en_irq_hold got=%b exp=1", core_irq_o); end
        core_intack_i = 1'b1; step(); core_intack_i = 1'b0;
        checks++; if (core_irq_o !== 1'b0) begin failures++; $display("FAIL en_irq_ack got=%b exp=0", core_irq_o); end
        core_intack_i = 1'b1; step(); core_intack_i = 1'b0;
        checks++; if (dut.r_state !== INTDST_SVC) begin failures++; $display("FAIL en_stray_ack state got=%0d exp=%0d", dut.r_state, INTDST_SVC); end
        intrqst_i = 1'b0; step(); step();
        core_eoi_i = 1'b1; step(); core_eoi_i = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (intcnt_o !== exp_cnt) begin failures++; $display("FAIL en_cnt got=%0d exp=%0d", intcnt_o, exp_cnt); end
        checks++; if (intrdy_o !== 1'b1) begin failures++; $display("FAIL en_rdy_back got=%b exp=1", intrdy_o); end
    endtask

    task automatic test_masked_and_drain();
        core_inten_i = 1'b0;
        step();
        checks++; if (intrdy_o !== 1'b0) begin failures++; $display("FAIL mk_rdy got=%b exp=0", intrdy_o); end
        intrqst_i = 1'b1; step();
        checks++; if (dut.r_state !== INTDST_PEND) begin failures++; $display("FAIL mk_pend got=%0d exp=%0d", dut.r_state, INTDST_PEND); end
        intrqst_i = 1'b0; step(); intrqst_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (core_irq_o !== 1'b0) begin failures++; $display("FAIL mk_irq_low cyc=%0d got=%b exp=0", i, core_irq_o); end
        end
        core_intack_i = 1'b1; step(); core_intack_i = 1'b0;
        checks++; if (dut.r_state !== INTDST_PEND) begin failures++; $display("FAIL mk_ack_ignored got=%0d exp=%0d", dut.r_state, INTDST_PEND); end
        core_eoi_i = 1'b1; step(); core_eoi_i = 1'b0;
        checks++; if (dut.r_state !== INTDST_PEND) begin failures++; $display("FAIL mk_eoi_ignored got=%0d exp=%0d", dut.r_state, INTDST_PEND); end
        core_inten_i = 1'b1; #1;
        checks++; if (core_irq_o !== 1'b1) begin failures++; $display("FAIL mk_irq_unmask got=%b exp=1", core_irq_o); end
        core_intack_i = 1'b1; step(); core_intack_i = 1'b0;
        checks++; if (dut.r_state !== INTDST_SVC) begin failures++; $display("FAIL dr_svc got=%0d exp=%0d", dut.r_state, INTDST_SVC); end
        core_eoi_i = 1'b1; step(); core_eoi_i = 1'b0;
        step(); step();
        checks++; if (dut.r_state !== INTDST_DRAIN) begin failures++; $display("FAIL dr_state got=%0d exp=%0d", dut.r_state, INTDST_DRAIN); end
        checks++; if (intcnt_o !== exp_cnt) begin failures++; $display("FAIL dr_cnt_hold got=%0d exp=%0d", intcnt_o, exp_cnt); end
        checks++; if (core_irq_o !== 1'b0) begin failures++; $display("FAIL dr_irq got=%b exp=0", core_irq_o); end
        intrqst_i = 1'b0; step();
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (intcnt_o !== exp_cnt) begin failures++; $display("FAIL dr_cnt got=%0d exp=%0d", intcnt_o, exp_cnt); end
        checks++; if (dut.r_state !== INTDST_IDLE) begin failures++; $display("FAIL dr_idle got=%0d exp=%0d", dut.r_state, INTDST_IDLE); end
    endtask

    task automatic test_best_delay();
        core_halted_i = 1'b1;
        for (int i = 1; i <= 8; i++) step();
        checks++; if (intbest_o !== 1'b0) begin failures++; $display("FAIL best_early got=%b exp=0", intbest_o); end
        step();
        checks++; if (intbest_o !== 1'b1) begin failures++; $display("FAIL best_rise got=%b exp=1", intbest_o); end
        for (int i = 0; i < 11; i++) step();
        checks++; if (intbest_o !== 1'b1) begin failures++; $display("FAIL best_hold got=%b exp=1", intbest_o); end
        core_halted_i = 1'b0; step();
        checks++; if (intbest_o !== 1'b0) begin failures++; $display("FAIL best_halt_fall got=%b exp=0", intbest_o); end
        core_halted_i = 1'b1;
        for (int i = 0; i < 9; i++) step();
        checks++; if (intbest_o !== 1'b1) begin failures++; $display("FAIL best_rerise got=%b exp=1", intbest_o); end
        intrqst_i = 1'b1; step();
        checks++; if (intbest_o !== 1'b0) begin failures++; $display("FAIL best_req_clr got=%b exp=0", intbest_o); end
        core_intack_i = 1'b1; step(); core_intack_i = 1'b0;
        intrqst_i = 1'b0; core_eoi_i = 1'b1; step(); core_eoi_i = 1'b0;
        core_halted_i = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (intcnt_o !== exp_cnt) begin failures++; $display("FAIL best_cnt got=%0d exp=%0d", intcnt_o, exp_cnt); end
    endtask

    task automatic test_reset_midop();
        intrqst_i = 1'b1; step();
        core_intack_i = 1'b1; step(); core_intack_i = 1'b0;
        checks++; if (intcnt_o !== 4'd3) begin failures++; $display("FAIL mid_cnt_pre got=%0d exp=3", intcnt_o); end
        rst_ni = 1'b0; step();
        checks++; if (intcnt_o !== 4'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", intcnt_o); end
        checks++; if (dut.r_state !== INTDST_IDLE) begin failures++; $display("FAIL mid_state got=%0d exp=%0d", dut.r_state, INTDST_IDLE); end
        checks++; if ({core_irq_o, intrdy_o, intbest_o} !== 3'b000) begin failures++; $display("FAIL mid_outs got=%b exp=000", {core_irq_o, intrdy_o, intbest_o}); end
        rst_ni = 1'b1; intrqst_i = 1'b0;
        core_eoi_i = 1'b1; step(); core_eoi_i = 1'b0;
        exp_cnt = 4'd0;
        checks++; if (intcnt_o !== exp_cnt) begin failures++; $display("FAIL mid_stray_eoi got=%0d exp=0", intcnt_o); end
        checks++; if (intrdy_o !== 1'b1) begin failures++; $display("FAIL mid_rdy got=%b exp=1", intrdy_o); end
    endtask

    task automatic test_back_to_back_wrap();
        for (int i = 0; i < 16; i++) begin
            intrqst_i = 1'b1; step();
            core_intack_i = 1'b1; core_eoi_i = 1'b1; step();
            core_intack_i = 1'b0; core_eoi_i = 1'b0;
            checks++; if (dut.r_state !== INTDST_SVC) begin failures++; $display("FAIL b2b_ack_eoi it=%0d got=%0d exp=%0d", i, dut.r_state, INTDST_SVC); end
            intrqst_i = 1'b0; core_eoi_i = 1'b1; step(); core_eoi_i = 1'b0;
            exp_cnt = exp_cnt + 4'd1;
            checks++; if (intcnt_o !== exp_cnt) begin failures++; $display("FAIL b2b_cnt it=%0d got=%0d exp=%0d", i, intcnt_o, exp_cnt); end
        end
        checks++; if (intcnt_o !== 4'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", intcnt_o); end
    endtask

    initial begin
        test_reset();
        test_enabled_path();
        test_masked_and_drain();
        test_best_delay();
        test_reset_midop();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
